// File: rtl/vga_frame_timer.sv
// vga_frame_timer: free-running VGA raster and frame sequencer.
// Produces registered x/y, sync, blanking, line/frame ticks and a 7-bit
// completed-frame counter. All outputs are registered from the same
// next-state position, so they always describe one raster position.
// Optional macro FRAME_RESTART_EN adds a 'restart' input that makes the
// next frame wrap load frame_counter with 0 instead of incrementing.
module vga_frame_timer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
`ifdef FRAME_RESTART_EN
  input  logic       restart,
`endif
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [6:0] frame_counter
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START_W = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END_W   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START_W = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END_W   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Counters are 10 bits wide; larger rasters cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_param_check
    $error("vga_frame_timer: H_TOTAL/V_TOTAL must be 1..1024 with non-empty active area");
  end

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       x_wrap;
  logic       y_wrap;
  logic       frame_wrap;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       display_on_nxt;
  logic       fc_clear;

  // Next raster position and the flags that describe it.
  always_comb begin
    x_wrap     = (x == H_LAST);
    y_wrap     = (y == V_LAST);
    frame_wrap = x_wrap & y_wrap;
    x_nxt      = x_wrap ? 10'd0 : x + 10'd1;
    y_nxt      = y;
    if (x_wrap) begin
      y_nxt = y_wrap ? 10'd0 : y + 10'd1;
    end
    hsync_nxt      = (({1'b0, x_nxt} >= HS_START_W) && ({1'b0, x_nxt} < HS_END_W)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt      = (({1'b0, y_nxt} >= VS_START_W) && ({1'b0, y_nxt} < VS_END_W)) ? SYNC_POL : ~SYNC_POL;
    display_on_nxt = ({1'b0, x_nxt} < H_ACT_W) && ({1'b0, y_nxt} < V_ACT_W);
  end

`ifdef FRAME_RESTART_EN
  logic restart_pend;

  assign fc_clear = restart_pend | restart;

  // Sticky restart request, consumed by the next frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      restart_pend <= 1'b0;
    end else if (ce && frame_wrap) begin
      restart_pend <= 1'b0;
    end else if (restart) begin
      restart_pend <= 1'b1;
    end
  end
`else
  assign fc_clear = 1'b0;
`endif

  // Raster position, registered flags and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      x             <= 10'd0;
      y             <= 10'd0;
      hsync         <= ~SYNC_POL;
      vsync         <= ~SYNC_POL;
      display_on    <= 1'b1;
      line_tick     <= 1'b1;
      frame_tick    <= 1'b1;
      frame_counter <= 7'd0;
    end else if (ce) begin
      x          <= x_nxt;
      y          <= y_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      display_on <= display_on_nxt;
      line_tick  <= (x_nxt == 10'd0);
      frame_tick <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
      if (frame_wrap) begin
        frame_counter <= fc_clear ? 7'd0 : frame_counter + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_timer.sv
// Testbench for vga_frame_timer: one default-timing instance and one
// small-raster instance (16x10 total) driven by the same inputs, each
// compared every cycle against an independent position model, plus
// directed checks with hand-computed values.
module tb_vga_frame_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic restart_in = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] s_x, s_y, d_x, d_y;
  logic       s_hs, s_vs, s_de, s_lt, s_ft;
  logic       d_hs, d_vs, d_de, d_lt, d_ft;
  logic [6:0] s_fc, d_fc;

  // Small raster: H 8+2+3+3=16 (hsync x=10..12), V 6+1+2+1=10 (vsync y=7..8)
  vga_frame_timer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef FRAME_RESTART_EN
    .restart(restart_in),
`endif
    .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
    .line_tick(s_lt), .frame_tick(s_ft), .frame_counter(s_fc)
  );

  vga_frame_timer dut_d (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef FRAME_RESTART_EN
    .restart(restart_in),
`endif
    .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
    .line_tick(d_lt), .frame_tick(d_ft), .frame_counter(d_fc)
  );

  int total = 0;
  int bad = 0;

  // Model tables: index 0 = small raster, 1 = default raster
  int ht[2]  = '{16, 800};
  int vt[2]  = '{10, 525};
  int ha[2]  = '{8, 640};
  int va[2]  = '{6, 480};
  int hss[2] = '{10, 656};
  int hse[2] = '{13, 752};
  int vss[2] = '{7, 490};
  int vse[2] = '{9, 492};
  int mx[2], my[2], mfc[2];
  bit mp[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_one(input int i, input logic [9:0] ox, input logic [9:0] oy,
                           input logic ohs, input logic ovs, input logic ode,
                           input logic olt, input logic oft, input logic [6:0] ofc);
    string p;
    p = (i == 0) ? "s_" : "d_";
    chk({p, "x"}, 32'(ox), 32'(mx[i]));
    chk({p, "y"}, 32'(oy), 32'(my[i]));
    chk({p, "fc"}, 32'(ofc), 32'(mfc[i]));
    chk({p, "hsync"}, 32'(ohs), (mx[i] >= hss[i] && mx[i] < hse[i]) ? 32'd0 : 32'd1);
    chk({p, "vsync"}, 32'(ovs), (my[i] >= vss[i] && my[i] < vse[i]) ? 32'd0 : 32'd1);
    chk({p, "display_on"}, 32'(ode), (mx[i] < ha[i] && my[i] < va[i]) ? 32'd1 : 32'd0);
    chk({p, "line_tick"}, 32'(olt), (mx[i] == 0) ? 32'd1 : 32'd0);
    chk({p, "frame_tick"}, 32'(oft), (mx[i] == 0 && my[i] == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input bit c, input bit r, input bit rs);
    bit xw, fw;
    ce = c;
    rst = r;
    restart_in = rs;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mx[i] = 0; my[i] = 0; mfc[i] = 0; mp[i] = 1'b0;
      end else begin
        xw = (mx[i] == ht[i] - 1);
        fw = xw && (my[i] == vt[i] - 1);
        if (c && fw) begin
          mfc[i] = (mp[i] || rs) ? 0 : (mfc[i] + 1) % 128;
          mp[i] = 1'b0;
        end else if (rs) begin
          mp[i] = 1'b1;
        end
        if (c) begin
          mx[i] = xw ? 0 : mx[i] + 1;
          if (xw) my[i] = (my[i] == vt[i] - 1) ? 0 : my[i] + 1;
        end
      end
    end
    check_one(0, s_x, s_y, s_hs, s_vs, s_de, s_lt, s_ft, s_fc);
    check_one(1, d_x, d_y, d_hs, d_vs, d_de, d_lt, d_ft, d_fc);
  endtask

  initial begin
    int hs_low, lt_cnt, de_cnt, vs_low, ft_cnt, x0;

    // Reset state
    step(1'b0, 1'b1, 1'b0);
    chk("rst_x", 32'(d_x), 32'd0);
    chk("rst_y", 32'(d_y), 32'd0);
    chk("rst_hsync", 32'(d_hs), 32'd1);
    chk("rst_vsync", 32'(d_vs), 32'd1);
    chk("rst_display_on", 32'(d_de), 32'd1);
    chk("rst_line_tick", 32'(d_lt), 32'd1);
    chk("rst_frame_tick", 32'(d_ft), 32'd1);
    chk("rst_fc", 32'(d_fc), 32'd0);

    // One default line
    hs_low = 0; lt_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      step(1'b1, 1'b0, 1'b0);
      if (d_hs == 1'b0) hs_low++;
      if (d_lt == 1'b1) lt_cnt++;
      if (d_x == 10'd656) chk("hs_start", 32'(d_hs), 32'd0);
      if (d_x == 10'd655) chk("hs_before", 32'(d_hs), 32'd1);
      if (d_x == 10'd751) chk("hs_last", 32'(d_hs), 32'd0);
      if (d_x == 10'd752) chk("hs_after", 32'(d_hs), 32'd1);
    end
    chk("line_x", 32'(d_x), 32'd0);
    chk("line_y", 32'(d_y), 32'd1);
    chk("hs_low_cnt", 32'(hs_low), 32'd96);
    chk("lt_cnt", 32'(lt_cnt), 32'd1);
    chk("small_fc_after_800", 32'(s_fc), 32'd5);

    // One small frame from reset
    step(1'b1, 1'b1, 1'b0);
    de_cnt = 0; vs_low = 0; ft_cnt = 0;
    for (int n = 0; n < 160; n++) begin
      step(1'b1, 1'b0, 1'b0);
      if (s_de) de_cnt++;
      if (!s_vs) vs_low++;
      if (s_ft) ft_cnt++;
    end
    chk("frame_de_cnt", 32'(de_cnt), 32'd48);
    chk("frame_vs_low", 32'(vs_low), 32'd32);
    chk("frame_ft_cnt", 32'(ft_cnt), 32'd1);
    chk("frame_fc", 32'(s_fc), 32'd1);
    chk("frame_x", 32'(s_x), 32'd0);
    chk("frame_y", 32'(s_y), 32'd0);

    // ce toggling: x advances once per two clocks
    x0 = int'(d_x);
    for (int n = 0; n < 40; n++) step(n[0] == 1'b0, 1'b0, 1'b0);
    chk("ce_toggle_x", 32'(d_x), 32'(x0 + 20));
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b0);
    chk("ce_hold_x", 32'(d_x), 32'(x0 + 20));

    // 127 frames then one more: frame_counter wraps 127 -> 0
    step(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 127 * 160; n++) step(1'b1, 1'b0, 1'b0);
    chk("fc_127", 32'(s_fc), 32'd127);
    chk("fc_127_ft", 32'(s_ft), 32'd1);
    for (int n = 0; n < 160; n++) step(1'b1, 1'b0, 1'b0);
    chk("fc_wrap", 32'(s_fc), 32'd0);
    chk("fc_wrap_ft", 32'(s_ft), 32'd1);

    // Mid-frame reset with ce low: reset dominates
    for (int n = 0; n < 3 * 16 + 5; n++) step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_x", 32'(s_x), 32'd5);
    chk("pre_rst_y", 32'(s_y), 32'd3);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_rst_x", 32'(s_x), 32'd0);
    chk("mid_rst_y", 32'(s_y), 32'd0);
    chk("mid_rst_fc", 32'(s_fc), 32'd0);
    chk("mid_rst_hsync", 32'(s_hs), 32'd1);
    chk("mid_rst_vsync", 32'(s_vs), 32'd1);
    chk("mid_rst_ft", 32'(s_ft), 32'd1);

`ifdef FRAME_RESTART_EN
    // Restart request mid-frame with frame_counter = 5
    for (int n = 0; n < 5 * 160 + 3 * 16; n++) step(1'b1, 1'b0, 1'b0);
    chk("rs_pre_fc", 32'(s_fc), 32'd5);
    step(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 160 - 3 * 16 - 1; n++) step(1'b1, 1'b0, 1'b0);
    chk("rs_hold_fc", 32'(s_fc), 32'd5);
    chk("rs_last_y", 32'(s_y), 32'd9);
    step(1'b1, 1'b0, 1'b0);
    chk("rs_wrap_fc", 32'(s_fc), 32'd0);
    chk("rs_wrap_x", 32'(s_x), 32'd0);
    chk("rs_wrap_y", 32'(s_y), 32'd0);
    for (int n = 0; n < 160; n++) step(1'b1, 1'b0, 1'b0);
    chk("rs_next_fc", 32'(s_fc), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
